max_pool_2d_ctrl: RTL and testbench
===================================

// Module: max_pool_2d_ctrl
// PURPOSE
//  Window scheduler for the combinational max_pool_2d datapath. Accepts a raster-order pixel stream (one
//  NFMAPS-wide pixel per beat), buffers KER_SIZE_Y-1 rows, assembles each non-overlapping
//  KER_SIZE_X x KER_SIZE_Y window (stride = kernel), drives it to max_pool_2d and returns the pooled
//  pixel on a valid/ready output stream with frame start/done sequencing.
// PARAMETERS
//  NBITS       8  bits per activation
//  NFMAPS      4  feature maps per pixel
//  KER_SIZE_X  2  pooling window width (and x stride)
//  KER_SIZE_Y  2  pooling window height (and y stride)
//  IMG_W       8  input frame width, pixels; must be a multiple of KER_SIZE_X (elaboration $error otherwise)
//  IMG_H       8  input frame height, pixels; must be a multiple of KER_SIZE_Y (elaboration $error otherwise)
// PORTS  (P = NBITS*NFMAPS, W = P*KER_SIZE_X*KER_SIZE_Y)
//  clk         in   1  single clock, all state on rising edge
//  rstn        in   1  asynchronous active-low reset
//  start       in   1  1-cycle pulse, begins a frame; honoured only in IDLE
//  busy        out  1  high in RUN and DRAIN
//  done        out  1  1-cycle pulse after the last output handshake
//  in_valid    in   1  input pixel valid
//  in_ready    out  1  input pixel accepted when in_valid && in_ready
//  in_act      in   P  input pixel, fmap f at [f*NBITS +: NBITS]
//  window_act  out  W  to max_pool_2d input_act; window element k = ky*KER_SIZE_X+kx at [k*P +: P]
//  pool_act    in   P  from max_pool_2d output_act
//  out_valid   out  1  pooled pixel valid
//  out_ready   in   1  downstream ready
//  out_act     out  P  pooled pixel (= pool_act)
//  out_last    out  1  high with out_valid on the final pooled pixel of the frame
// BEHAVIOUR
//  - Reset (async, rstn=0): state=IDLE, x_cnt=y_cnt=0, out_valid=0, out_last=0, done=0, busy=0,
//    in_ready=0, window register=0. Line buffer storage is not reset (contents don't-care).
//  - FSM: IDLE -start-> RUN; RUN -last window completes-> DRAIN; DRAIN -out handshake-> DONE;
//    DONE -> IDLE (done=1 for exactly this cycle). start outside IDLE ignored.
//  - in_ready = (state==RUN) && !(out_valid && !out_ready). No input accepted in IDLE/DRAIN/DONE.
//  - Counters: each accepted pixel advances x_cnt 0..IMG_W-1; wrap to 0 increments y_cnt 0..IMG_H-1.
//  - Rows with y_cnt%KER_SIZE_Y < KER_SIZE_Y-1 are written to line buffer lb[y_cnt%KER_SIZE_Y][x_cnt].
//  - Rows with y_cnt%KER_SIZE_Y == KER_SIZE_Y-1: pixel shifts into a (KER_SIZE_X-1)-deep row register;
//    when x_cnt%KER_SIZE_X == KER_SIZE_X-1 the window register loads lb columns x_cnt-KER_SIZE_X+1..x_cnt,
//    rows 0..KER_SIZE_Y-2, plus the row register and current pixel as row KER_SIZE_Y-1, and
//    out_valid is set on the same edge.
//  - Latency: window-completing pixel accepted at edge N -> out_valid=1 and window_act stable after edge N.
//  - out_act = pool_act (combinational through max_pool_2d); window_act held until out handshake.
//  - out_valid clears on out_valid&&out_ready unless a new window completes on that same edge (then it
//    stays 1 with the new window; possible only when out_ready=1, so no overwrite of an unacked window).
//  - out_last = out_valid on window at x_cnt=IMG_W-1, y_cnt=IMG_H-1. Outputs per frame:
//    (IMG_W/KER_SIZE_X)*(IMG_H/KER_SIZE_Y).
//  - in_valid while in_ready=0: pixel not consumed, counters unchanged. Reset mid-frame discards frame;
//    next frame requires a new start.
// TESTING  (override IMG_W=IMG_H=4, NBITS=8, NFMAPS=4, KER 2x2; real max_pool_2d instantiated)
//  1 start, pixel (x,y) all fmaps = 4*y+x, in_valid always, out_ready=1 -> outputs 5,7,13,15 per fmap,
//    out_last on 15, done pulse one cycle after its handshake, busy low after.
//  2 fmap f = 16*f+(4*y+x), checkerboard negative values excluded -> per-fmap outputs independent, correct.
//  3 out_ready=0 for 5 cycles after first out_valid -> in_ready=0 during stall, out_act holds 5, no loss.
//  4 start pulsed during RUN -> ignored, counters continue, exactly 4 outputs.
//  5 rstn=0 after 6 accepted pixels -> all outputs zero immediately; new start + full frame gives test-1 values.
//  6 random in_valid/out_ready gaps, 3 back-to-back frames -> output sequence matches scoreboard.

Source files
------------

// File: rtl/max_pool_2d_ctrl_if.sv
// Stream, frame-control and datapath-side signals of the max-pool window scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding logic.
interface max_pool_2d_ctrl_if #(
  parameter int NBITS      = 8,
  parameter int NFMAPS     = 4,
  parameter int KER_SIZE_X = 2,
  parameter int KER_SIZE_Y = 2
);
  localparam int P = NBITS * NFMAPS;
  localparam int W = P * KER_SIZE_X * KER_SIZE_Y;

  logic         start;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] in_act;
  logic [W-1:0] window_act;
  logic [P-1:0] pool_act;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out_act;
  logic         out_last;

  modport slave (
    input  start, in_valid, in_act, pool_act, out_ready,
    output busy, done, in_ready, window_act, out_valid, out_act, out_last
  );

  modport master (
    output start, in_valid, in_act, pool_act, out_ready,
    input  busy, done, in_ready, window_act, out_valid, out_act, out_last
  );
endinterface

// File: rtl/max_pool_2d.sv
// Combinational max-pool datapath: signed per-fmap maximum over one
// KER_SIZE_X x KER_SIZE_Y window of NFMAPS-wide pixels.
module max_pool_2d #(
  parameter int NBITS      = 8,
  parameter int NFMAPS     = 4,
  parameter int KER_SIZE_X = 2,
  parameter int KER_SIZE_Y = 2
) (
  input  logic [NBITS*NFMAPS*KER_SIZE_X*KER_SIZE_Y-1:0] input_act,
  output logic [NBITS*NFMAPS-1:0]                       output_act
);
  localparam int P = NBITS * NFMAPS;
  localparam int K = KER_SIZE_X * KER_SIZE_Y;

  logic [NBITS-1:0] best;
  logic [NBITS-1:0] cand;

  always_comb begin
    output_act = '0;
    best       = '0;
    cand       = '0;
    for (int f = 0; f < NFMAPS; f++) begin
      best = input_act[f*NBITS +: NBITS];
      for (int k = 1; k < K; k++) begin
        cand = input_act[k*P + f*NBITS +: NBITS];
        if ($signed(cand) > $signed(best)) best = cand;
      end
      output_act[f*NBITS +: NBITS] = best;
    end
  end
endmodule

// File: rtl/max_pool_2d_ctrl.sv
// Window scheduler for max_pool_2d: buffers KER_SIZE_Y-1 rows of a raster pixel stream,
// assembles non-overlapping windows and returns pooled pixels on a valid/ready stream.
module max_pool_2d_ctrl #(
  parameter int NBITS      = 8,
  parameter int NFMAPS     = 4,
  parameter int KER_SIZE_X = 2,
  parameter int KER_SIZE_Y = 2,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input logic            clk,
  input logic            rstn,
  max_pool_2d_ctrl_if.slave bus
);
  localparam int P   = NBITS * NFMAPS;
  localparam int W   = P * KER_SIZE_X * KER_SIZE_Y;
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int KXW = $clog2(KER_SIZE_X);
  localparam int KYW = $clog2(KER_SIZE_Y);
  localparam int RRD = KER_SIZE_X - 1;

  if (IMG_W % KER_SIZE_X != 0) begin : g_bad_w
    $error("IMG_W must be a multiple of KER_SIZE_X");
  end
  if (IMG_H % KER_SIZE_Y != 0) begin : g_bad_h
    $error("IMG_H must be a multiple of KER_SIZE_Y");
  end
  if (KER_SIZE_X < 2 || KER_SIZE_Y < 2) begin : g_bad_k
    $error("kernel dimensions below 2 are not supported");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [XW-1:0]    x_cnt;
  logic [YW-1:0]    y_cnt;
  logic [KXW-1:0]   kx_cnt;
  logic [KYW-1:0]   ky_cnt;
  logic [P-1:0]     lb [KER_SIZE_Y-1][IMG_W];
  logic [P-1:0]     rowreg [RRD];
  logic [W-1:0]     window;
  logic [W-1:0]     next_win;
  logic [XW-1:0]    xbase;
  logic             out_valid_q, out_last_q, done_q, busy_q;
  logic             accept, last_row, kx_last, x_end, y_end, win_done;

  // kx_cnt/ky_cnt track the position inside the kernel so no modulo is needed
  assign x_end    = (x_cnt == XW'(IMG_W - 1));
  assign y_end    = (y_cnt == YW'(IMG_H - 1));
  assign kx_last  = (kx_cnt == KXW'(KER_SIZE_X - 1));
  assign last_row = (ky_cnt == KYW'(KER_SIZE_Y - 1));
  assign bus.in_ready = (state == S_RUN) && !(out_valid_q && !bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign win_done = accept && last_row && kx_last;
  assign xbase    = x_cnt - XW'(KER_SIZE_X - 1);

  always_comb begin
    next_win = '0;
    for (int r = 0; r < KER_SIZE_Y - 1; r++)
      for (int c = 0; c < KER_SIZE_X; c++)
        next_win[(r*KER_SIZE_X + c)*P +: P] = lb[r][xbase + XW'(c)];
    for (int c = 0; c < RRD; c++)
      next_win[((KER_SIZE_Y-1)*KER_SIZE_X + c)*P +: P] = rowreg[c];
    next_win[W-P +: P] = bus.in_act;
  end

  // Line buffer and row register hold data only; their contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KER_SIZE_Y - 1; r++)
        if (ky_cnt == KYW'(r)) lb[r][x_cnt] <= bus.in_act;
      if (last_row) begin
        for (int c = 0; c < RRD - 1; c++) rowreg[c] <= rowreg[c+1];
        rowreg[RRD-1] <= bus.in_act;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      kx_cnt      <= '0;
      ky_cnt      <= '0;
      window      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_RUN;
            busy_q <= 1'b1;
            x_cnt  <= '0;
            y_cnt  <= '0;
            kx_cnt <= '0;
            ky_cnt <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (x_end) begin
              x_cnt  <= '0;
              kx_cnt <= '0;
              y_cnt  <= y_end ? '0 : y_cnt + 1'b1;
              ky_cnt <= last_row ? '0 : ky_cnt + 1'b1;
            end else begin
              x_cnt  <= x_cnt + 1'b1;
              kx_cnt <= kx_last ? '0 : kx_cnt + 1'b1;
            end
          end
          // a new window may only land on an edge where the previous one is acknowledged
          if (win_done) begin
            window      <= next_win;
            out_valid_q <= 1'b1;
            out_last_q  <= x_end && y_end;
            if (x_end && y_end) state <= S_DRAIN;
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.window_act = window;
  assign bus.out_act    = bus.pool_act;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_max_pool_2d_ctrl.sv
// Bench for max_pool_2d_ctrl with the real max_pool_2d datapath: a window-level
// reference model fills an expected queue that one negedge process checks against.
module tb_max_pool_2d_ctrl;
  localparam int NB = 8, NF = 4, KX = 2, KY = 2, IW = 4, IH = 4;
  localparam int P = NB * NF;
  localparam int NPIX = IW * IH;
  localparam int NOUT = (IW / KX) * (IH / KY);

  typedef struct {
    logic [P-1:0] act;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  max_pool_2d_ctrl_if #(.NBITS(NB), .NFMAPS(NF), .KER_SIZE_X(KX), .KER_SIZE_Y(KY)) bus();

  max_pool_2d_ctrl #(.NBITS(NB), .NFMAPS(NF), .KER_SIZE_X(KX), .KER_SIZE_Y(KY),
                     .IMG_W(IW), .IMG_H(IH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  max_pool_2d #(.NBITS(NB), .NFMAPS(NF), .KER_SIZE_X(KX), .KER_SIZE_Y(KY))
    u_mp (.input_act(bus.window_act), .output_act(bus.pool_act));

  exp_t         exp_q[$];
  logic [P-1:0] obs_q[$];
  logic [P-1:0] pix [NPIX];
  logic [7:0]   lit1 [4] = '{8'd5, 8'd7, 8'd13, 8'd15};
  int n_cmp = 0, n_err = 0;
  int cyc = 0, hs_cyc = -10, n_out = 0;
  int gap_pct = 0, rdy_mode = 0, extra_start = 0;
  bit stall_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output checker: every cycle with out_valid, compare against the head of the model queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          check("out_act", bus.out_act, exp_q[0].act);
          check("out_last", bus.out_last, exp_q[0].last);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            obs_q.push_back(bus.out_act);
            n_out++;
            if (bus.out_last) hs_cyc = cyc;
          end
        end
        if (!bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
      end
      if (bus.done) check("done_timing", cyc, hs_cyc + 1);
    end
  end

  // Downstream ready: 0 = always, 1 = random, 2 = 5-cycle stall on first out_valid
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 99) >= 40);
      else if (rdy_mode == 2 && bus.out_valid && !stall_done) begin
        stall_done = 1'b1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end else bus.out_ready = 1'b1;
    end
  end

  // Frame model: pixels per mode, then one expected entry per pooling window.
  function automatic void build(input int mode);
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++)
        for (int f = 0; f < NF; f++) begin
          logic [7:0] v;
          if (mode == 0)      v = 8'(4*y + x);
          else if (mode == 1) v = 8'(16*f + 4*y + x);
          else                v = 8'($urandom);
          pix[y*IW + x][f*NB +: NB] = v;
        end
    for (int wy = 0; wy < IH/KY; wy++)
      for (int wx = 0; wx < IW/KX; wx++) begin
        exp_t e;
        e.act = '0;
        for (int f = 0; f < NF; f++) begin
          int m;
          m = -1000;
          for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++) begin
              int v;
              v = int'($signed(pix[(wy*KY + ky)*IW + wx*KX + kx][f*NB +: NB]));
              if (v > m) m = v;
            end
          e.act[f*NB +: NB] = 8'(m);
        end
        e.last = (wy == IH/KY - 1) && (wx == IW/KX - 1);
        exp_q.push_back(e);
      end
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_act   = pix[i];
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
      end
      if (!acc) check("in_accept_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check("done_seen", seen, 1);
    check("busy_in_done", bus.busy, 0);
    check("in_ready_in_done", bus.in_ready, 0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("busy_after", bus.busy, 0);
  endtask

  task automatic run_frame(input int mode);
    n_out = 0;
    obs_q.delete();
    build(mode);
    pulse_start();
    check("busy_run", bus.busy, 1);
    check("in_ready_run", bus.in_ready, 1);
    if (extra_start != 0) begin
      fork
        begin
          repeat (6) @(posedge clk);
          #1 bus.start = 1'b1;
          @(posedge clk);
          #1 bus.start = 1'b0;
        end
      join_none
    end
    send_pixels(NPIX);
    wait_done();
    check("n_out", n_out, NOUT);
    check("exp_left", exp_q.size(), 0);
  endtask

  task automatic check_obs_test1();
    for (int i = 0; i < NOUT; i++) begin
      if (i < obs_q.size()) check("obs_pin", obs_q[i], {4{lit1[i]}});
      else check("obs_missing", 0, 1);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_act = '0;
    #2 rstn = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_window", bus.window_act, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: ramp frame, pinned literal outputs
    build(0);
    for (int i = 0; i < NOUT; i++) check("model_pin1", exp_q[i].act, {4{lit1[i]}});
    check("model_pin1_last", exp_q[NOUT-1].last, 1);
    exp_q.delete();
    run_frame(0);
    check_obs_test1();

    // 2: independent fmaps
    run_frame(1);
    if (obs_q.size() > 3) begin
      check("obs_pin2_0", obs_q[0], {8'd53, 8'd37, 8'd21, 8'd5});
      check("obs_pin2_3", obs_q[3], {8'd63, 8'd47, 8'd31, 8'd15});
    end else check("obs_pin2_missing", obs_q.size(), 4);

    // 3: 5-cycle output stall
    rdy_mode = 2; stall_done = 1'b0;
    run_frame(0);
    check_obs_test1();
    rdy_mode = 0;

    // 4: start during RUN ignored
    extra_start = 1;
    run_frame(0);
    check_obs_test1();
    extra_start = 0;

    // 5: reset mid-frame
    build(0);
    pulse_start();
    send_pixels(6);
    rstn = 1'b0;
    #1;
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_out_last", bus.out_last, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_in_ready", bus.in_ready, 0);
    check("mrst_window", bus.window_act, 0);
    check("mrst_out_act", bus.out_act, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus.in_valid = 1'b1; bus.in_act = 32'h01010101;
    repeat (4) begin
      @(negedge clk);
      check("idle_in_ready", bus.in_ready, 0);
      check("idle_out_valid", bus.out_valid, 0);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    run_frame(0);
    check_obs_test1();

    // 6: random gaps and backpressure, back-to-back frames
    gap_pct = 30; rdy_mode = 1;
    for (int fr = 0; fr < 3; fr++) run_frame(2);
    gap_pct = 0; rdy_mode = 0;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
